// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/debug memory port arbiter: FSM states, port ids,
// and the reset value of the round-robin history.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DONE  = 2'd2
   } arb_state_t;

   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_DBG = 1'b1
   } port_id_t;

   // Debug counts as most recently served out of reset, so the CPU wins the first tie.
   localparam port_id_t LAST_RST = PORT_DBG;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker. With lock set and debug served
// last, the CPU request is masked so debug keeps the memory.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] i_req,
   input  port_id_t   i_last,
   input  logic       i_lock,
   output logic       o_valid,
   output port_id_t   o_winner
);

   logic [1:0] w_req;

   always_comb begin
      w_req    = i_req;
      o_winner = PORT_CPU;
      if (i_lock && (i_last == PORT_DBG)) begin
         w_req[0] = 1'b0;
      end
      o_valid = |w_req;
      if (w_req == 2'b10) begin
         o_winner = PORT_DBG;
      end else if (w_req == 2'b11) begin
         o_winner = (i_last == PORT_CPU) ? PORT_DBG : PORT_CPU;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory between the CPU MAR/MDR path and a debug/loader port,
// one access at a time. Define ARB_LOCK_EN to add the i_dbg_lock bus lock.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 1
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cpu_req,
   input  logic              i_cpu_we,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic              o_cpu_ack,
   output logic [DATA_W-1:0] o_cpu_rdata,
   input  logic              i_dbg_req,
   input  logic              i_dbg_we,
   input  logic [ADDR_W-1:0] i_dbg_addr,
   input  logic [DATA_W-1:0] i_dbg_wdata,
   output logic              o_dbg_ack,
   output logic [DATA_W-1:0] o_dbg_rdata,
`ifdef ARB_LOCK_EN
   input  logic              i_dbg_lock,
`endif
   output logic              o_mem_rw,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_data,
   input  logic [DATA_W-1:0] i_mem_data,
   output logic              o_busy
);

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   arb_state_t        r_state;
   arb_state_t        w_next_state;
   port_id_t          r_last;
   port_id_t          r_port;
   port_id_t          w_winner;
   logic              w_pick_valid;
   logic              w_lock;
   logic              r_we;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_cpu_ack;
   logic              r_dbg_ack;
   logic              r_mem_rw;
   logic              r_busy;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_data;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic [DATA_W-1:0] r_dbg_rdata;

`ifdef ARB_LOCK_EN
   assign w_lock = i_dbg_lock;
`else
   assign w_lock = 1'b0;
`endif

   rr_pick2 u_pick (
      .i_req    ({i_dbg_req, i_cpu_req}),
      .i_last   (r_last),
      .i_lock   (w_lock),
      .o_valid  (w_pick_valid),
      .o_winner (w_winner)
   );

   always_comb begin
      w_sel_we    = i_cpu_we;
      w_sel_addr  = i_cpu_addr;
      w_sel_wdata = i_cpu_wdata;
      if (w_winner == PORT_DBG) begin
         w_sel_we    = i_dbg_we;
         w_sel_addr  = i_dbg_addr;
         w_sel_wdata = i_dbg_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_pick_valid) w_next_state = GRANT;
         GRANT:   if (r_cnt == '0) w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // The write strobe is registered one edge early so it lands in the final GRANT cycle.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_last      <= LAST_RST;
         r_port      <= PORT_CPU;
         r_we        <= 1'b0;
         r_cnt       <= '0;
         r_cpu_ack   <= 1'b0;
         r_dbg_ack   <= 1'b0;
         r_mem_rw    <= 1'b0;
         r_busy      <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_data  <= '0;
         r_cpu_rdata <= '0;
         r_dbg_rdata <= '0;
      end else begin
         r_cpu_ack <= 1'b0;
         r_dbg_ack <= 1'b0;
         r_mem_rw  <= 1'b0;
         r_busy    <= (w_next_state != IDLE);
         case (r_state)
            IDLE: begin
               if (w_pick_valid) begin
                  r_port     <= w_winner;
                  r_last     <= w_winner;
                  r_we       <= w_sel_we;
                  r_mem_addr <= w_sel_addr;
                  r_mem_data <= w_sel_wdata;
                  r_cnt      <= CNT_W'(MEM_LAT - 1);
                  r_mem_rw   <= w_sel_we && (MEM_LAT == 1);
               end
            end
            GRANT: begin
               if (r_cnt != '0) begin
                  r_cnt    <= r_cnt - CNT_W'(1);
                  r_mem_rw <= r_we && (r_cnt == CNT_W'(1));
               end else if (r_port == PORT_CPU) begin
                  r_cpu_ack <= 1'b1;
                  if (!r_we) r_cpu_rdata <= i_mem_data;
               end else begin
                  r_dbg_ack <= 1'b1;
                  if (!r_we) r_dbg_rdata <= i_mem_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_cpu_ack   = r_cpu_ack;
   assign o_dbg_ack   = r_dbg_ack;
   assign o_cpu_rdata = r_cpu_rdata;
   assign o_dbg_rdata = r_dbg_rdata;
   assign o_mem_rw    = r_mem_rw;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_data  = r_mem_data;
   assign o_busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance 0 runs MEM_LAT=1, instance 1
// runs MEM_LAT=3, each with its own behavioural memory.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req [2];
   logic        cpu_we  [2];
   logic [7:0]  cpu_addr [2];
   logic [15:0] cpu_wdata [2];
   logic        cpu_ack [2];
   logic [15:0] cpu_rdata [2];
   logic        dbg_req [2];
   logic        dbg_we  [2];
   logic [7:0]  dbg_addr [2];
   logic [15:0] dbg_wdata [2];
   logic        dbg_ack [2];
   logic [15:0] dbg_rdata [2];
`ifdef ARB_LOCK_EN
   logic        dbg_lock [2];
`endif
   logic        mem_rw [2];
   logic [7:0]  mem_addr [2];
   logic [15:0] mem_wd [2];
   logic [15:0] mem_rd [2];
   logic        busy [2];

   logic [15:0] mem_a [256];
   logic [15:0] mem_b [256];
   logic        pl_en;
   logic        pl_sel;
   logic [7:0]  pl_addr;
   logic [15:0] pl_data;

   int total = 0;
   int bad = 0;
   int cyc_cnt = 0;
   int rw_cnt [2];
   int rw_cyc [2];
   int ack_cnt [2];
   logic [7:0]  rw_addr [2];
   logic [15:0] rw_data [2];
   logic [0:0]  exp_q [$];

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(1)) u_lat1 (
      .i_clk(clk), .i_rst(rst_n),
      .i_cpu_req(cpu_req[0]), .i_cpu_we(cpu_we[0]), .i_cpu_addr(cpu_addr[0]),
      .i_cpu_wdata(cpu_wdata[0]), .o_cpu_ack(cpu_ack[0]), .o_cpu_rdata(cpu_rdata[0]),
      .i_dbg_req(dbg_req[0]), .i_dbg_we(dbg_we[0]), .i_dbg_addr(dbg_addr[0]),
      .i_dbg_wdata(dbg_wdata[0]), .o_dbg_ack(dbg_ack[0]), .o_dbg_rdata(dbg_rdata[0]),
`ifdef ARB_LOCK_EN
      .i_dbg_lock(dbg_lock[0]),
`endif
      .o_mem_rw(mem_rw[0]), .o_mem_addr(mem_addr[0]), .o_mem_data(mem_wd[0]),
      .i_mem_data(mem_rd[0]), .o_busy(busy[0])
   );

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(3)) u_lat3 (
      .i_clk(clk), .i_rst(rst_n),
      .i_cpu_req(cpu_req[1]), .i_cpu_we(cpu_we[1]), .i_cpu_addr(cpu_addr[1]),
      .i_cpu_wdata(cpu_wdata[1]), .o_cpu_ack(cpu_ack[1]), .o_cpu_rdata(cpu_rdata[1]),
      .i_dbg_req(dbg_req[1]), .i_dbg_we(dbg_we[1]), .i_dbg_addr(dbg_addr[1]),
      .i_dbg_wdata(dbg_wdata[1]), .o_dbg_ack(dbg_ack[1]), .o_dbg_rdata(dbg_rdata[1]),
`ifdef ARB_LOCK_EN
      .i_dbg_lock(dbg_lock[1]),
`endif
      .o_mem_rw(mem_rw[1]), .o_mem_addr(mem_addr[1]), .o_mem_data(mem_wd[1]),
      .i_mem_data(mem_rd[1]), .o_busy(busy[1])
   );

   // Asynchronous-read memories; bench preload shares the write port.
   assign mem_rd[0] = mem_a[mem_addr[0]];
   assign mem_rd[1] = mem_b[mem_addr[1]];

   always @(posedge clk) begin
      if (pl_en && !pl_sel) mem_a[pl_addr] <= pl_data;
      else if (mem_rw[0])   mem_a[mem_addr[0]] <= mem_wd[0];
   end

   always @(posedge clk) begin
      if (pl_en && pl_sel) mem_b[pl_addr] <= pl_data;
      else if (mem_rw[1])  mem_b[mem_addr[1]] <= mem_wd[1];
   end

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (mem_rw[d] === 1'b1) begin
            rw_cnt[d]  <= rw_cnt[d] + 1;
            rw_cyc[d]  <= cyc_cnt;
            rw_addr[d] <= mem_addr[d];
            rw_data[d] <= mem_wd[d];
         end
         if (cpu_ack[d] === 1'b1 || dbg_ack[d] === 1'b1) ack_cnt[d] <= ack_cnt[d] + 1;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_cpu(input int d, input logic req, input logic we,
                          input logic [7:0] a, input logic [15:0] wd);
      cpu_req[d] = req; cpu_we[d] = we; cpu_addr[d] = a; cpu_wdata[d] = wd;
   endtask

   task automatic set_dbg(input int d, input logic req, input logic we,
                          input logic [7:0] a, input logic [15:0] wd);
      dbg_req[d] = req; dbg_we[d] = we; dbg_addr[d] = a; dbg_wdata[d] = wd;
   endtask

   task automatic preload(input logic sel, input logic [7:0] a, input logic [15:0] v);
      pl_en = 1'b1; pl_sel = sel; pl_addr = a; pl_data = v;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   // Returns edges from request drive until ack is seen, -1 on timeout.
   task automatic wait_ack(input int d, input logic port, output int cyc);
      cyc = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if ((port ? dbg_ack[d] : cpu_ack[d]) === 1'b1) begin
            cyc = i;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      for (int d = 0; d < 2; d++) begin
         total++;
         if ({cpu_ack[d], dbg_ack[d], mem_rw[d], busy[d]} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl[%0d] got=%b exp=0000", d,
                     {cpu_ack[d], dbg_ack[d], mem_rw[d], busy[d]});
         end
         total++;
         if ({mem_addr[d], mem_wd[d]} !== 24'h0) begin
            bad++;
            $display("FAIL reset_mem_bus[%0d] got=%h exp=0", d, {mem_addr[d], mem_wd[d]});
         end
         total++;
         if ({cpu_rdata[d], dbg_rdata[d]} !== 32'h0) begin
            bad++;
            $display("FAIL reset_rdata[%0d] got=%h exp=0", d, {cpu_rdata[d], dbg_rdata[d]});
         end
      end
   endtask

   task automatic test_cpu_read_lat1();
      int cyc;
      int rw0;
      preload(1'b0, 8'h10, 16'hBEEF);
      rw0 = rw_cnt[0];
      set_cpu(0, 1'b1, 1'b0, 8'h10, 16'h0);
      wait_ack(0, 1'b0, cyc);
      set_cpu(0, 1'b0, 1'b0, 8'h0, 16'h0);
      total++;
      if (cyc !== 2) begin bad++; $display("FAIL lat1_ack_latency got=%0d exp=2", cyc); end
      total++;
      if (cpu_rdata[0] !== 16'hBEEF) begin
         bad++; $display("FAIL lat1_cpu_rdata got=%h exp=beef", cpu_rdata[0]);
      end
      @(posedge clk); #1;
      total++;
      if (cpu_ack[0] !== 1'b0) begin bad++; $display("FAIL lat1_ack_width got=%b exp=0", cpu_ack[0]); end
      total++;
      if (rw_cnt[0] != rw0) begin
         bad++; $display("FAIL lat1_read_no_strobe got=%0d exp=0", rw_cnt[0] - rw0);
      end
   endtask

   task automatic test_dbg_write_lat3();
      int cyc;
      int rw0;
      int start;
      preload(1'b1, 8'h20, 16'h0000);
      rw0 = rw_cnt[1];
      start = cyc_cnt;
      set_dbg(1, 1'b1, 1'b1, 8'h20, 16'h1234);
      wait_ack(1, 1'b1, cyc);
      set_dbg(1, 1'b0, 1'b0, 8'h0, 16'h0);
      total++;
      if (cyc !== 4) begin bad++; $display("FAIL lat3_ack_latency got=%0d exp=4", cyc); end
      total++;
      if (rw_cnt[1] - rw0 != 1) begin
         bad++; $display("FAIL lat3_strobe_count got=%0d exp=1", rw_cnt[1] - rw0);
      end
      total++;
      if (rw_cyc[1] != start + 3) begin
         bad++; $display("FAIL lat3_strobe_cycle got=%0d exp=%0d", rw_cyc[1] - start, 3);
      end
      total++;
      if ({rw_addr[1], rw_data[1]} !== {8'h20, 16'h1234}) begin
         bad++; $display("FAIL lat3_strobe_bus got=%h/%h exp=20/1234", rw_addr[1], rw_data[1]);
      end
      total++;
      if (mem_b[8'h20] !== 16'h1234) begin
         bad++; $display("FAIL lat3_mem_written got=%h exp=1234", mem_b[8'h20]);
      end
   endtask

   task automatic test_round_robin();
      int n = 0;
      int c = 0;
      int last_c = 0;
      logic port;
      logic [0:0] expp;
      preload(1'b1, 8'h40, 16'hC0C0);
      preload(1'b1, 8'h50, 16'hD0D0);
      exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      set_cpu(1, 1'b1, 1'b0, 8'h40, 16'h0);
      set_dbg(1, 1'b1, 1'b0, 8'h50, 16'h0);
      while (n < 6 && c < 100) begin
         @(posedge clk); #1;
         c++;
         if (cpu_ack[1] === 1'b1 || dbg_ack[1] === 1'b1) begin
            port = dbg_ack[1];
            expp = exp_q.pop_front();
            total++;
            if (port !== expp[0]) begin
               bad++; $display("FAIL rr_order[%0d] got=%b exp=%b", n, port, expp[0]);
            end
            total++;
            if (cpu_rdata[1] !== 16'hC0C0) begin
               bad++; $display("FAIL rr_cpu_rdata[%0d] got=%h exp=c0c0", n, cpu_rdata[1]);
            end
            if (port) begin
               total++;
               if (dbg_rdata[1] !== 16'hD0D0) begin
                  bad++; $display("FAIL rr_dbg_rdata[%0d] got=%h exp=d0d0", n, dbg_rdata[1]);
               end
            end
            if (n > 0) begin
               total++;
               if (c - last_c != 5) begin
                  bad++; $display("FAIL rr_throughput[%0d] got=%0d exp=5", n, c - last_c);
               end
            end
            last_c = c;
            n++;
         end
      end
      set_cpu(1, 1'b0, 1'b0, 8'h0, 16'h0);
      set_dbg(1, 1'b0, 1'b0, 8'h0, 16'h0);
      total++;
      if (n != 6) begin bad++; $display("FAIL rr_ack_count got=%0d exp=6", n); end
   endtask

   task automatic test_reset_mid();
      int rw0;
      int a0;
      preload(1'b1, 8'h60, 16'h0000);
      rw0 = rw_cnt[1];
      a0 = ack_cnt[1];
      set_cpu(1, 1'b1, 1'b1, 8'h60, 16'h5555);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      set_cpu(1, 1'b0, 1'b0, 8'h0, 16'h0);
      @(posedge clk); #1;
      total++;
      if ({cpu_ack[1], dbg_ack[1], mem_rw[1], busy[1]} !== 4'b0000) begin
         bad++; $display("FAIL rstmid_ctrl got=%b exp=0000", {cpu_ack[1], dbg_ack[1], mem_rw[1], busy[1]});
      end
      total++;
      if ({mem_addr[1], mem_wd[1], cpu_rdata[1], dbg_rdata[1]} !== 56'h0) begin
         bad++; $display("FAIL rstmid_data got=%h exp=0",
                         {mem_addr[1], mem_wd[1], cpu_rdata[1], dbg_rdata[1]});
      end
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      total++;
      if (rw_cnt[1] != rw0) begin bad++; $display("FAIL rstmid_strobe got=%0d exp=0", rw_cnt[1] - rw0); end
      total++;
      if (ack_cnt[1] != a0) begin bad++; $display("FAIL rstmid_ack got=%0d exp=0", ack_cnt[1] - a0); end
      total++;
      if (mem_b[8'h60] !== 16'h0000) begin
         bad++; $display("FAIL rstmid_mem got=%h exp=0000", mem_b[8'h60]);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      preload(1'b0, 8'h11, 16'h1111);
      preload(1'b0, 8'h12, 16'h2222);
      set_cpu(0, 1'b1, 1'b0, 8'h10, 16'h0);
      wait_ack(0, 1'b0, cyc);
      total++;
      if (cyc !== 2 || cpu_rdata[0] !== 16'hBEEF) begin
         bad++; $display("FAIL b2b_first got=%0d/%h exp=2/beef", cyc, cpu_rdata[0]);
      end
      cpu_addr[0] = 8'h11;
      @(posedge clk); #1;
      total++;
      if ({cpu_ack[0], busy[0]} !== 2'b00) begin
         bad++; $display("FAIL b2b_idle got=%b exp=00", {cpu_ack[0], busy[0]});
      end
      @(posedge clk); #1;
      cpu_addr[0] = 8'h12;
      total++;
      if (mem_addr[0] !== 8'h11) begin bad++; $display("FAIL b2b_grant_addr got=%h exp=11", mem_addr[0]); end
      @(posedge clk); #1;
      total++;
      if (cpu_ack[0] !== 1'b1 || cpu_rdata[0] !== 16'h1111) begin
         bad++; $display("FAIL b2b_second got=%b/%h exp=1/1111", cpu_ack[0], cpu_rdata[0]);
      end
      set_cpu(0, 1'b0, 1'b0, 8'h0, 16'h0);
      @(posedge clk); #1;
      total++;
      if ({cpu_ack[0], busy[0]} !== 2'b00) begin
         bad++; $display("FAIL b2b_end got=%b exp=00", {cpu_ack[0], busy[0]});
      end
   endtask

`ifdef ARB_LOCK_EN
   task automatic test_lock();
      int cyc;
      int n = 0;
      int c = 0;
      set_dbg(1, 1'b1, 1'b0, 8'h50, 16'h0);
      wait_ack(1, 1'b1, cyc);
      total++;
      if (cyc !== 4) begin bad++; $display("FAIL lock_first got=%0d exp=4", cyc); end
      dbg_lock[1] = 1'b1;
      set_cpu(1, 1'b1, 1'b0, 8'h40, 16'h0);
      while (n < 4 && c < 100) begin
         @(posedge clk); #1;
         c++;
         if (cpu_ack[1] === 1'b1 || dbg_ack[1] === 1'b1) begin
            total++;
            if (dbg_ack[1] !== (n < 3)) begin
               bad++; $display("FAIL lock_order[%0d] got_dbg=%b exp_dbg=%b", n, dbg_ack[1], n < 3);
            end
            n++;
            if (n == 3) dbg_lock[1] = 1'b0;
         end
      end
      set_cpu(1, 1'b0, 1'b0, 8'h0, 16'h0);
      set_dbg(1, 1'b0, 1'b0, 8'h0, 16'h0);
      total++;
      if (n != 4) begin bad++; $display("FAIL lock_ack_count got=%0d exp=4", n); end
      repeat (6) @(posedge clk);
      #1;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      pl_en = 1'b0; pl_sel = 1'b0; pl_addr = '0; pl_data = '0;
      for (int d = 0; d < 2; d++) begin
         set_cpu(d, 1'b0, 1'b0, 8'h0, 16'h0);
         set_dbg(d, 1'b0, 1'b0, 8'h0, 16'h0);
         rw_cnt[d] = 0; rw_cyc[d] = 0; ack_cnt[d] = 0;
`ifdef ARB_LOCK_EN
         dbg_lock[d] = 1'b0;
`endif
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      test_reset();
      test_cpu_read_lat1();
      test_dbg_write_lat3();
      test_round_robin();
      test_reset_mid();
      test_back_to_back();
`ifdef ARB_LOCK_EN
      test_lock();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
